timer_report: RTL and testbench
===============================

Name: timer_report

Overview:
- Reader-side companion to the millisecond timer.
- On a trigger pulse it snapshots the timer's 18-bit status word {ena, ovflw, cnt[15:0]} and streams it as an ASCII frame over a byte valid/ready interface feeding the UART transmitter.
- Gives firmware-free visibility of timer state on the serial console.
- Counts triggers it cannot service.

Parameters:
- HEX_UPPER, 1, 1: hex digits A-F sent as 0x41-0x46; 0: sent as 0x61-0x66.
- SEND_CRLF, 1, 1: frame ends with 0x0D 0x0A (9 bytes); 0: no terminator (7 bytes).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- trig  in  1  single-cycle request to snapshot and report.
- tmr_din  in  18  timer status {ena[17], ovflw[16], cnt[15:0]}.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on the cycle the final byte transfers.
- clr_drop  in  1  synchronous clear of the drop counter.
- dropped  out  8  saturating count of ignored triggers.

Behaviour:
- Reset (async, immediate):
  - tx_valid=0, tx_data=0x00, busy=0, done=0, dropped=0.
  - Snapshot register and byte index cleared; state=IDLE.
- States: IDLE, SEND.
- IDLE:
  - trig=1 at edge N: capture tmr_din into the snapshot register, index=0, go to SEND.
  - From edge N: busy=1, tx_valid=1, tx_data=0x54 ('T'). Latency is 1 cycle from trig to the first valid byte.
- Frame, index 0..8:
  - 'T'
  - ena as '0'/'1' (0x30/0x31)
  - ovflw as '0'/'1'
  - cnt[15:12], cnt[11:8], cnt[7:4], cnt[3:0] as hex ASCII
  - 0x0D, 0x0A (only if SEND_CRLF=1)
- Hex encoding:
  - 0-9 map to 0x30-0x39.
  - 10-15 map to 0x41-0x46 (HEX_UPPER=1) or 0x61-0x66 (HEX_UPPER=0).
- Handshake:
  - A transfer occurs at an edge where tx_valid and tx_ready are both 1.
  - tx_data and tx_valid are held stable until the transfer.
  - After a non-final transfer, the next byte is presented the following cycle; tx_valid stays high, giving back-to-back throughput of 1 byte per cycle.
  - tx_valid never deasserts mid-frame except on reset.
- Frame content comes only from the snapshot. Changes on tmr_din after capture do not affect the frame in flight.
- Final-byte transfer:
  - done=1 for that cycle.
  - Without a concurrent trig: next state IDLE, busy=0, tx_valid=0.
- trig on the same cycle as the final-byte transfer:
  - A new snapshot is taken and the new frame starts with 'T' on the next cycle; busy stays 1.
  - Not counted as dropped.
- Any other trig while busy=1 is ignored: no snapshot change, dropped increments.
- dropped saturates at 0xFF.
- clr_drop=1 sets dropped to 0. If clr_drop and a dropped trig occur in the same cycle, dropped becomes 1.
- Reset mid-frame aborts immediately. Nothing resumes after release; the next trig starts a fresh frame.
- tmr_din is assumed synchronous to clk; no CDC logic.

Test Plan:
- Basic frame, HEX_UPPER=1, SEND_CRLF=1: tmr_din=0x21A2F (ena=1, ovflw=0, cnt=0x1A2F), tx_ready=1, trig pulse -> bytes 0x54 0x31 0x30 0x31 0x41 0x32 0x46 0x0D 0x0A on 9 consecutive cycles starting 1 cycle after trig; done high with 0x0A; busy low afterward.
- Backpressure and snapshot hold: tmr_din=0x1FFFF, trig, tx_ready held 0 for 5 cycles on byte 3 while tmr_din changes to 0x00000 -> tx_data held at 0x46 with tx_valid=1 for all 5 cycles; frame is 'T','0','1','F','F','F','F',CR,LF.
- Lowercase, no CRLF (HEX_UPPER=0, SEND_CRLF=0): cnt=0xBEEF, ena=0, ovflw=0 -> 7 bytes 0x54 0x30 0x30 0x62 0x65 0x65 0x66; done on the 7th byte.
- Drops and back-to-back:
  - 3 trig pulses mid-frame -> dropped=3.
  - trig on the final-byte cycle -> second frame starts the next cycle and dropped stays 3.
  - 300 mid-frame trigs -> dropped=0xFF.
  - clr_drop together with a dropped trig -> dropped=1.
- Reset mid-frame: assert rst asynchronously during byte 4 -> tx_valid, busy, dropped go to 0 immediately. After release, a trig with tmr_din=0x00001 -> full fresh frame 'T','0','0','0','0','0','1',CR,LF.

Source files
------------

// File: rtl/timer_report.sv
// Snapshots the millisecond timer status on a trigger and streams it
// as an ASCII frame ("T", ena, ovflw, 4 hex digits, optional CRLF).
module timer_report #(
    parameter bit HEX_UPPER = 1'b1,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig,
    input  logic [17:0] tmr_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    input  logic        clr_drop,
    output logic [7:0]  dropped
);

    localparam logic [3:0] LAST_IDX = SEND_CRLF ? 4'd8 : 4'd6;

    typedef enum logic {IDLE, SEND} state_e;

    state_e      state_q;
    logic [17:0] snap_q;
    logic [3:0]  idx_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;
    logic [7:0]  drop_q;
    logic [7:0]  drop_d;

    logic xfer;
    logic last_xfer;
    logic start;
    logic drop_hit;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'd0, n};
        end
        return (HEX_UPPER ? 8'h37 : 8'h57) + {4'd0, n};
    endfunction

    function automatic logic [7:0] frame_byte(
        input logic [17:0] snap,
        input logic [3:0]  idx
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0:    b = 8'h54;
            4'd1:    b = {7'b0011000, snap[17]};
            4'd2:    b = {7'b0011000, snap[16]};
            4'd3:    b = hex_ascii(snap[15:12]);
            4'd4:    b = hex_ascii(snap[11:8]);
            4'd5:    b = hex_ascii(snap[7:4]);
            4'd6:    b = hex_ascii(snap[3:0]);
            4'd7:    b = 8'h0D;
            4'd8:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign xfer      = valid_q & tx_ready;
    assign last_xfer = xfer & (idx_q == LAST_IDX);
    // A trigger landing on the final transfer chains a new frame
    assign start     = trig & ((state_q == IDLE) | last_xfer);
    assign drop_hit  = trig & busy_q & ~last_xfer;

    always_comb begin
        drop_d = drop_q;
        if (clr_drop) begin
            drop_d = {7'd0, drop_hit};
        end else if (drop_hit && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= '0;
        end else begin
            drop_q <= drop_d;
            if (start) begin
                state_q <= SEND;
                snap_q  <= tmr_din;
                idx_q   <= 4'd0;
                data_q  <= 8'h54;
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
            end else if (last_xfer) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else if (xfer) begin
                idx_q  <= idx_q + 4'd1;
                data_q <= frame_byte(snap_q, idx_q + 4'd1);
            end
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign busy     = busy_q;
    assign done     = last_xfer;
    assign dropped  = drop_q;

endmodule

// File: tb/tb_timer_report.sv
// Bench for timer_report: two configurations (upper+CRLF, lower+bare)
// share stimulus and are checked against a frame-queue reference model.
module tb_timer_report;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig;
    logic        clr_drop;
    logic        tx_ready;
    logic [17:0] tmr_din;
    logic [15:0] txd;
    logic [15:0] drp;
    logic [1:0]  txv;
    logic [1:0]  bsy;
    logic [1:0]  dne;

    int checks = 0;
    int errors = 0;

    byte unsigned fb[2][16];
    int cnt[2];
    int pos[2];
    int mdrop[2];
    bit m_v, m_xf, m_fin, m_dr;

    always #5 clk = ~clk;

    timer_report #(.HEX_UPPER(1'b1), .SEND_CRLF(1'b1)) u_up (
        .clk(clk), .rst(rst), .trig(trig), .tmr_din(tmr_din),
        .tx_data(txd[7:0]), .tx_valid(txv[0]), .tx_ready(tx_ready),
        .busy(bsy[0]), .done(dne[0]), .clr_drop(clr_drop),
        .dropped(drp[7:0])
    );

    timer_report #(.HEX_UPPER(1'b0), .SEND_CRLF(1'b0)) u_lo (
        .clk(clk), .rst(rst), .trig(trig), .tmr_din(tmr_din),
        .tx_data(txd[15:8]), .tx_valid(txv[1]), .tx_ready(tx_ready),
        .busy(bsy[1]), .done(dne[1]), .clr_drop(clr_drop),
        .dropped(drp[15:8])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Build the expected ASCII frame for instance k from a status word
    task automatic load(input int k, input logic [17:0] d);
        logic [3:0] nib;
        int n;
        fb[k][0] = 8'h54;
        fb[k][1] = d[17] ? 8'h31 : 8'h30;
        fb[k][2] = d[16] ? 8'h31 : 8'h30;
        for (int i = 0; i < 4; i++) begin
            nib = d[15-4*i -: 4];
            if (nib < 4'd10)
                fb[k][3+i] = 8'h30 + nib;
            else
                fb[k][3+i] = (k == 0 ? 8'h41 : 8'h61) + nib - 8'd10;
        end
        n = 7;
        if (k == 0) begin
            fb[k][7] = 8'h0D;
            fb[k][8] = 8'h0A;
            n = 9;
        end
        cnt[k] = n;
        pos[k] = 0;
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cnt[k]   = 0;
                pos[k]   = 0;
                mdrop[k] = 0;
            end
            m_v = (cnt[k] != 0);
            chk($sformatf("u%0d_valid", k), txv[k], m_v);
            chk($sformatf("u%0d_busy", k), bsy[k], m_v);
            chk($sformatf("u%0d_done", k), dne[k],
                m_v && tx_ready && cnt[k] == 1);
            chk($sformatf("u%0d_dropped", k), drp[8*k +: 8], mdrop[k]);
            if (m_v)
                chk($sformatf("u%0d_data", k), txd[8*k +: 8],
                    fb[k][pos[k]]);
            if (!rst) begin
                m_xf  = m_v && tx_ready;
                m_fin = m_xf && cnt[k] == 1;
                if (m_xf) begin
                    pos[k]++;
                    cnt[k]--;
                end
                m_dr = trig && m_v && !m_fin;
                if (trig && (!m_v || m_fin))
                    load(k, tmr_din);
                if (clr_drop)
                    mdrop[k] = m_dr ? 1 : 0;
                else if (m_dr && mdrop[k] < 255)
                    mdrop[k]++;
            end
        end
    end

    task automatic cyc(input bit t, input logic [17:0] d,
                       input bit r, input bit c);
        @(posedge clk);
        #1;
        trig     = t;
        tmr_din  = d;
        tx_ready = r;
        clr_drop = c;
    endtask

    function automatic logic [17:0] rnd();
        return 18'($urandom);
    endfunction

    initial begin
        rst = 1'b1;
        trig = 1'b0;
        clr_drop = 1'b0;
        tx_ready = 1'b0;
        tmr_din = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        cyc(1, 18'h21A2F, 1, 0);
        repeat (12) cyc(0, rnd(), 1, 0);

        cyc(1, 18'h1FFFF, 1, 0);
        repeat (3) cyc(0, 18'h1FFFF, 1, 0);
        repeat (5) cyc(0, 18'h00000, 0, 0);
        repeat (12) cyc(0, 18'h00000, 1, 0);

        cyc(0, rnd(), 1, 1);
        cyc(1, 18'h0BEEF, 1, 0);
        for (int k = 1; k <= 9; k++)
            cyc(k inside {2, 3, 4, 9}, rnd(), 1, 0);
        cyc(0, rnd(), 1, 0);
        chk("b2b_busy", bsy[0], 1);
        chk("b2b_first", txd[7:0], 8'h54);
        chk("drop3", drp[7:0], 3);

        repeat (20) cyc(0, rnd(), 1, 0);
        cyc(1, rnd(), 0, 0);
        repeat (300) cyc(1, rnd(), 0, 0);
        cyc(0, rnd(), 0, 0);
        chk("drop_sat", drp[7:0], 8'hFF);
        cyc(1, rnd(), 0, 1);
        cyc(0, rnd(), 0, 0);
        chk("clr_with_drop", drp[7:0], 1);
        repeat (12) cyc(0, rnd(), 1, 0);

        cyc(1, rnd(), 1, 0);
        repeat (4) cyc(0, rnd(), 1, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_valid", txv[0], 0);
        chk("rst_busy", bsy[0], 0);
        chk("rst_dropped", drp[7:0], 0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1, 18'h00001, 1, 0);
        repeat (12) cyc(0, rnd(), 1, 0);

        repeat (3000)
            cyc($urandom % 6 == 0, rnd(), $urandom % 4 != 0,
                $urandom % 50 == 0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
